// File: rtl/muldiv_sequencer.sv
// ============================================================================
//  muldiv_sequencer
//  Sequences the EX-stage pipelined multiplier and divider IPs: clock enables,
//  pipeline stall, result capture. Optional feature macro: DIVZERO_BYPASS_EN.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module muldiv_sequencer #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic [2:0]  func,
  input  logic [15:0] denom,
  input  logic [31:0] mult_result,
  input  logic [15:0] div_quotient,
  input  logic        hold,
  input  logic        flush,
  output logic        mult_ce,
  output logic        div_ce,
  output logic        ex_stall,
  output logic        done,
  output logic [15:0] result,
  output logic        divzero
);

  localparam logic [3:0] c_mult_lat = 4'(MULT_LAT);
  localparam logic [3:0] c_div_lat  = 4'(DIV_LAT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MULT = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [15:0] r_result;
  logic        r_divzero;

  logic w_live;
  logic w_acc_mul;
  logic w_acc_div;
  logic w_dz;
  logic w_unused_bits;

  // Reset and flush both mask every request seen this cycle.
  assign w_live    = rst_n && !flush;
  assign w_acc_mul = w_live && req && (func == 3'b000);
  assign w_acc_div = w_live && req && (func == 3'b001);

`ifdef DIVZERO_BYPASS_EN
  assign w_dz = (denom == 16'h0000);
`else
  assign w_dz = 1'b0;
`endif

  assign w_unused_bits = ^{mult_result[31:16], denom};

  always_comb begin
    mult_ce  = 1'b0;
    div_ce   = 1'b0;
    ex_stall = 1'b0;
    done     = 1'b0;
    if (w_live) begin
      case (r_state)
        S_IDLE: begin
          if (w_acc_mul) begin
            mult_ce  = 1'b1;
            ex_stall = 1'b1;
          end else if (w_acc_div) begin
            div_ce   = !w_dz;
            ex_stall = 1'b1;
          end
        end
        S_MULT: begin
          ex_stall = 1'b1;
          mult_ce  = !hold && (r_cnt != c_mult_lat);
        end
        S_DIV: begin
          ex_stall = 1'b1;
          div_ce   = !hold && (r_cnt != c_div_lat);
        end
        default: done = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_result  <= 16'h0000;
      r_divzero <= 1'b0;
    end else if (flush) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_acc_mul) begin
            r_state   <= S_MULT;
            r_cnt     <= 4'd1;
            r_divzero <= 1'b0;
          end else if (w_acc_div) begin
            if (w_dz) begin
              r_state   <= S_DONE;
              r_cnt     <= 4'd0;
              r_result  <= 16'hFFFF;
              r_divzero <= 1'b1;
            end else begin
              r_state   <= S_DIV;
              r_cnt     <= 4'd1;
              r_divzero <= 1'b0;
            end
          end
        end
        S_MULT: begin
          if (!hold) begin
            if (r_cnt == c_mult_lat) begin
              r_state  <= S_DONE;
              r_cnt    <= 4'd0;
              r_result <= mult_result[15:0];
            end else begin
              r_cnt <= r_cnt + 4'd1;
            end
          end
        end
        S_DIV: begin
          if (!hold) begin
            if (r_cnt == c_div_lat) begin
              r_state  <= S_DONE;
              r_cnt    <= 4'd0;
              r_result <= div_quotient;
            end else begin
              r_cnt <= r_cnt + 4'd1;
            end
          end
        end
        default: begin
          // The instruction leaves EX only when downstream releases hold.
          if (!hold) begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign result  = r_result;
  assign divzero = r_divzero;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
// ============================================================================
//  tb_muldiv_sequencer
//  Directed self-checking bench for muldiv_sequencer (default latencies 5/7).
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_muldiv_sequencer;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic [2:0]  func;
  logic [15:0] denom;
  logic [31:0] mult_result;
  logic [15:0] div_quotient;
  logic        hold;
  logic        flush;
  logic        mult_ce;
  logic        div_ce;
  logic        ex_stall;
  logic        done;
  logic [15:0] result;
  logic        divzero;

  int n_cmp;
  int n_bad;

  muldiv_sequencer #(.MULT_LAT(5), .DIV_LAT(7)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .func         (func),
    .denom        (denom),
    .mult_result  (mult_result),
    .div_quotient (div_quotient),
    .hold         (hold),
    .flush        (flush),
    .mult_ce      (mult_ce),
    .div_ce       (div_ce),
    .ex_stall     (ex_stall),
    .done         (done),
    .result       (result),
    .divzero      (divzero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one op from IDLE until done is seen (at a negedge), counting stall and
  // CE cycles; hold is raised for cycles [ha, ha+hl) counted from acceptance.
  task automatic run_op(input logic [2:0] f, input int ha, input int hl,
                        output int stall_n, output int ce_n, output int ce_other,
                        output int ce_hold, output bit got_done);
    stall_n = 0; ce_n = 0; ce_other = 0; ce_hold = 0; got_done = 1'b0;
    req = 1'b1;
    func = f;
    for (int cyc = 0; cyc < 40; cyc++) begin
      hold = (cyc >= ha) && (cyc < ha + hl);
      @(negedge clk);
      if (done) begin
        got_done = 1'b1;
        break;
      end
      if (ex_stall) stall_n++;
      if ((f == 3'b000) ? mult_ce : div_ce) begin
        ce_n++;
        if (hold) ce_hold++;
      end
      if ((f == 3'b000) ? div_ce : mult_ce) ce_other++;
      step();
    end
    hold = 1'b0;
  endtask

  int  st, ce, co, ch;
  bit  gd;

  initial begin
    n_cmp = 0; n_bad = 0;
    rst_n = 1'b0; req = 1'b0; func = 3'b000; denom = 16'd3;
    mult_result = 32'h0001_0006; div_quotient = 16'h0004;
    hold = 1'b0; flush = 1'b0;

    repeat (2) step();
    check("rst_stall",   {31'd0, ex_stall}, 32'd0);
    check("rst_done",    {31'd0, done},     32'd0);
    check("rst_result",  {16'd0, result},   32'd0);
    check("rst_divzero", {31'd0, divzero},  32'd0);
    rst_n = 1'b1;
    step();

    // Plain multiply
    run_op(3'b000, 99, 0, st, ce, co, ch, gd);
    check("mul_done",   {31'd0, gd}, 32'd1);
    check("mul_stall",  st, 32'd6);
    check("mul_ce",     ce, 32'd5);
    check("mul_div_ce", co, 32'd0);
    check("mul_result", {16'd0, result}, 32'h0006);
    check("mul_done_stall", {31'd0, ex_stall}, 32'd0);
    req = 1'b0;
    step();
    @(negedge clk);
    check("mul_done_1cyc", {31'd0, done}, 32'd0);
    step();

    // Plain divide
    run_op(3'b001, 99, 0, st, ce, co, ch, gd);
    check("div_done",    {31'd0, gd}, 32'd1);
    check("div_stall",   st, 32'd8);
    check("div_ce",      ce, 32'd7);
    check("div_mul_ce",  co, 32'd0);
    check("div_result",  {16'd0, result}, 32'h0004);
    check("div_divzero", {31'd0, divzero}, 32'd0);
    req = 1'b0;
    step();

    // Multiply with 2 hold cycles at cnt=3, then hold while in DONE
    mult_result = 32'hABCD_1234;
    run_op(3'b000, 3, 2, st, ce, co, ch, gd);
    check("hmul_done",   {31'd0, gd}, 32'd1);
    check("hmul_stall",  st, 32'd8);
    check("hmul_ce",     ce, 32'd5);
    check("hmul_ce_hold", ch, 32'd0);
    check("hmul_result", {16'd0, result}, 32'h1234);
    hold = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      @(negedge clk);
      check("dhold_done",  {31'd0, done}, 32'd1);
      check("dhold_stall", {31'd0, ex_stall}, 32'd0);
      check("dhold_ce",    {31'd0, mult_ce | div_ce}, 32'd0);
    end
    step();
    hold = 1'b0;
    req = 1'b0;
    step();
    @(negedge clk);
    check("dhold_idle_done",  {31'd0, done}, 32'd0);
    check("dhold_idle_stall", {31'd0, ex_stall}, 32'd0);
    step();

    // Flush a divide at cnt=4
    div_quotient = 16'hBEEF;
    req = 1'b1; func = 3'b001; denom = 16'd3;
    repeat (4) step();
    flush = 1'b1;
    @(negedge clk);
    check("fl_stall", {31'd0, ex_stall}, 32'd0);
    check("fl_ce",    {31'd0, div_ce},   32'd0);
    check("fl_done",  {31'd0, done},     32'd0);
    step();
    flush = 1'b0;
    req = 1'b0;
    @(negedge clk);
    check("fl_idle_stall", {31'd0, ex_stall}, 32'd0);
    check("fl_idle_done",  {31'd0, done},     32'd0);
    check("fl_result",     {16'd0, result},   32'h1234);
    step();

    // Non-multi-cycle func
    req = 1'b1; func = 3'b010;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("f010_act", {29'd0, ex_stall, mult_ce, div_ce}, 32'd0);
      check("f010_done", {31'd0, done}, 32'd0);
      step();
    end
    req = 1'b0;

    // Divide by zero
    denom = 16'h0000;
    div_quotient = 16'h5555;
    run_op(3'b001, 99, 0, st, ce, co, ch, gd);
    check("dz_done", {31'd0, gd}, 32'd1);
`ifdef DIVZERO_BYPASS_EN
    check("dz_stall",   st, 32'd1);
    check("dz_ce",      ce, 32'd0);
    check("dz_result",  {16'd0, result}, 32'hFFFF);
    check("dz_divzero", {31'd0, divzero}, 32'd1);
`else
    check("dz_stall",   st, 32'd8);
    check("dz_ce",      ce, 32'd7);
    check("dz_result",  {16'd0, result}, 32'h5555);
    check("dz_divzero", {31'd0, divzero}, 32'd0);
`endif
    req = 1'b0;
    denom = 16'd3;
    step();

    // Reset in the middle of a multiply
    req = 1'b1; func = 3'b000;
    repeat (2) step();
    check("rmul_divzero_clr", {31'd0, divzero}, 32'd0);
    rst_n = 1'b0;
    step();
    @(negedge clk);
    check("rmul_act",     {29'd0, ex_stall, mult_ce, div_ce}, 32'd0);
    check("rmul_done",    {31'd0, done},    32'd0);
    check("rmul_result",  {16'd0, result},  32'd0);
    check("rmul_divzero", {31'd0, divzero}, 32'd0);
    rst_n = 1'b1;
    req = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Sequencer for the EX-stage multi-cycle arithmetic units: the pipelined multiplier IP (MULT_LAT clocks) and divider IP (DIV_LAT clocks). The block accepts a mult/div instruction held in EX, gates each IP's clock enable, raises the pipeline stall for exactly the required cycles, and captures the 16-bit result into a holding register. It also absorbs downstream holds and flushes. It replaces the free-running stall counters in ex_logic, and its result feeds the lc3x result mux.

## Interface
- MULT_LAT, 5, multiplier IP latency in enabled clock edges (1..15)
- DIV_LAT, 7, divider IP latency in enabled clock edges (1..15)

- clk  input  1  clock; all state changes on the rising edge
- rst_n  input  1  reset, synchronous, active-low
- req  input  1  EX holds a valid mult_div instruction (level)
- func  input  3  ex_ir[5:3]: 000 = multiply, 001 = divide, other values = not a multi-cycle op
- denom  input  16  divider denominator (immsr2 path), used for divide-by-zero detection
- mult_result  input  32  multiplier IP output; bits [15:0] are used
- div_quotient  input  16  divider IP quotient
- hold  input  1  downstream pipeline stall; freezes sequencing
- flush  input  1  EX instruction squashed (branch or trap)
- mult_ce  output  1  multiplier clock enable
- div_ce  output  1  divider clock enable
- ex_stall  output  1  stall request to the pipeline
- done  output  1  result valid in `result`
- result  output  16  captured product[15:0] or quotient
- divzero  output  1  the divide in DONE had denom == 0

## Operation
- The FSM has four states: IDLE, MULT, DIV, DONE. A 4-bit counter `cnt` counts enabled edges.
- IDLE:
  - req=1, func=000, flush=0: mult_ce=1 and ex_stall=1 this cycle. Next state MULT, cnt←1.
  - req=1, func=001, flush=0: div_ce=1 and ex_stall=1. Next state DIV, cnt←1.
  - req=0 or other func: all outputs 0, stay in IDLE.
- MULT and DIV:
  - ex_stall=1.
  - CE = !hold; cnt increments only when hold=0.
  - When cnt==LAT and hold=0: CE=0, and result←mult_result[15:0] or div_quotient. Next state DONE.
  - The cnt==LAT cycle still asserts ex_stall.
- DONE:
  - done=1, ex_stall=0, both CEs 0, result held.
  - hold=0 → IDLE. hold=1 → stay in DONE. Re-acceptance never happens while the same instruction sits in EX.
- Flush in any state: next state IDLE, cnt←0. In the flush cycle, CEs=0 and ex_stall=0. `result` keeps its old value and done=0.
- req dropping in MULT/DIV without flush is a protocol error. The block completes the operation regardless.
- LAT = 1: the cnt==LAT condition is met in the first MULT/DIV cycle.

## Timing
- Reset (rst_n=0 at an edge): state IDLE, cnt=0, result=0, divzero=0. Combinational outputs follow IDLE with req gated off.
  - Reset has priority over flush, hold and req.
  - Reset mid-operation abandons the IP pipeline contents.
- ex_stall, mult_ce, div_ce and done are combinational from state, cnt, req, func, hold and flush.
  - The block is Moore in MULT, DIV and DONE.
  - It is Mealy in IDLE, so the stall appears in the same cycle the instruction enters EX.
- With hold=0 throughout:
  - Multiply: ex_stall is high for MULT_LAT+1 cycles (6 by default), then done is high for 1 cycle.
  - Divide: ex_stall is high for DIV_LAT+1 cycles (8 by default), then done is high.
- Each hold cycle during MULT/DIV extends the stall by one cycle. The number of CE-high cycles is always exactly LAT.
- Simultaneous flush and hold: flush wins.

## Configuration
- DIVZERO_BYPASS_EN defined:
  - In IDLE, a divide with denom==16'h0000 never enables the divider.
  - Next state DONE with result←16'hFFFF and divzero←1. The stall lasts 1 cycle.
  - Any other accepted operation clears divzero.
- Not defined:
  - A zero denominator runs the normal DIV sequence and captures whatever the IP produces.
  - divzero is tied to 0.

## Test plan
- Multiply:
  - Stimulus: reset, then req=1, func=000, IP returns 32'h0001_0006.
  - Required: mult_ce high 5 cycles, ex_stall high 6 cycles, then done=1 with result=16'h0006.
- Divide:
  - Stimulus: req=1, func=001, denom=3, quotient=16'h0004.
  - Required: div_ce high 7 cycles, ex_stall high 8 cycles, then done=1 with result=16'h0004.
- Hold during a multiply:
  - Stimulus: hold=1 for 2 cycles at cnt=3.
  - Required: mult_ce low during those 2 cycles, ex_stall high 8 cycles in total, result still correct.
  - Stimulus: hold=1 in DONE.
  - Required: the block stays in DONE with no re-acceptance, then returns to IDLE after hold drops.
- Flush mid-divide at cnt=4:
  - Required: next cycle state is IDLE with ex_stall=0, and result is unchanged from its previous value.
  - Stimulus: rst_n=0 mid-multiply.
  - Required: all outputs 0 on the next cycle.
- Non-multi-cycle func and divide by zero:
  - Stimulus: func=010 with req=1.
  - Required: no CE and no stall.
  - Stimulus: divide with denom=0, DIVZERO_BYPASS_EN defined.
  - Required: 1 stall cycle, result=16'hFFFF, divzero=1.
  - Stimulus: divide with denom=0, macro not defined.
  - Required: the full 8-cycle stall and divzero=0.
